chase_steer: RTL and testbench

Steering controller that consumes per-frame blob measurements from the colour tracker (horizontal centroid and radius) and drives the robot's two wheel motors. It runs a search/track/hold state machine, converts centroid error into differential wheel duty, and generates glitch-free PWM and direction outputs for the motor driver pins. It sits downstream of the tracker in the 65 MHz video clock domain.

---
 rtl/chase_steer.sv | 200 ++++++++++++++++++++
 tb/tb_chase_steer.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/chase_steer.sv
// Steering controller: search/track/hold FSM turning tracker blob measurements
// into differential wheel duty, with period-synchronous PWM and direction outputs.
module chase_steer #(
  parameter int FRAME_W     = 1024,
  parameter int CENTER_TOL  = 64,
  parameter int R_MIN       = 4,
  parameter int R_NEAR      = 60,
  parameter int R_HYST      = 8,
  parameter int LOST_FRAMES = 8,
  parameter int BASE_DUTY   = 160,
  parameter int SEARCH_DUTY = 96,
  parameter int TURN_SHIFT  = 3,
  parameter int PWM_DIV     = 256
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        meas_valid,
  input  logic [10:0] x_center,
  input  logic [11:0] radius,
  output logic        pwm_l,
  output logic        pwm_r,
  output logic        dir_l,
  output logic        dir_r,
  output logic [1:0]  state
);

  typedef enum logic [1:0] {IDLE = 2'd0, SEARCH = 2'd1, TRACK = 2'd2, HOLD = 2'd3} state_t;

  localparam int PRE_W  = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;
  localparam int MISS_W = $clog2(LOST_FRAMES + 1);
  localparam logic signed [11:0] HALF_W   = 12'(FRAME_W / 2);
  localparam logic [11:0]        R_MIN_V  = 12'(R_MIN);
  localparam logic [11:0]        R_NEAR_V = 12'(R_NEAR);
  localparam logic [11:0]        R_LEAVE_V = 12'(R_NEAR - R_HYST);
  localparam logic [11:0]        TOL_V    = 12'(CENTER_TOL);
  localparam logic [11:0]        BASE_V12 = 12'(BASE_DUTY);
  localparam logic [7:0]         BASE_V   = 8'(BASE_DUTY);
  localparam logic [7:0]         SEARCH_V = 8'(SEARCH_DUTY);
  localparam logic [PRE_W-1:0]   PRE_LAST = PRE_W'(PWM_DIV - 1);
  localparam logic [MISS_W-1:0]  MISS_LAST = MISS_W'(LOST_FRAMES - 1);

  // Correction never exceeds the base duty, so the inner wheel cannot underflow.
  function automatic logic [7:0] corr_sat(input logic [11:0] m);
    return (m > BASE_V12) ? BASE_V : m[7:0];
  endfunction

  function automatic logic [7:0] duty_sat(input logic [7:0] base, input logic [7:0] c);
    logic [8:0] s;
    s = {1'b0, base} + {1'b0, c};
    return s[8] ? 8'hFF : s[7:0];
  endfunction

  state_t             state_q, state_d;
  logic [MISS_W-1:0]  miss_q, miss_d;
  logic signed [11:0] err_q, err_d;
  logic [PRE_W-1:0]   pre_q, pre_d;
  logic [7:0]         cnt_q, cnt_d;
  logic [7:0]         act_duty_l_q, act_duty_l_d, act_duty_r_q, act_duty_r_d;
  logic               act_dir_l_q, act_dir_l_d, act_dir_r_q, act_dir_r_d;
  logic               pwm_l_q, pwm_l_d, pwm_r_q, pwm_r_d;

  logic               detected;
  logic signed [11:0] meas_err;
  logic [11:0]        mag;
  logic [7:0]         corr, outer, inner;
  logic [7:0]         tgt_duty_l, tgt_duty_r;
  logic               tgt_dir_l, tgt_dir_r;
  logic               pre_wrap, period_start;

  assign detected = (radius >= R_MIN_V);
  assign meas_err = $signed({1'b0, x_center}) - HALF_W;

  always_comb begin
    state_d = state_q;
    miss_d  = miss_q;
    err_d   = err_q;
    if (!enable) begin
      state_d = IDLE;
      miss_d  = '0;
    end else begin
      if (meas_valid && detected && (state_q != IDLE)) err_d = meas_err;
      case (state_q)
        IDLE:   state_d = SEARCH;
        SEARCH: if (meas_valid && detected) begin
          state_d = TRACK;
          miss_d  = '0;
        end
        TRACK, HOLD: if (meas_valid) begin
          if (!detected) begin
            if (miss_q == MISS_LAST) begin
              state_d = SEARCH;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + MISS_W'(1);
            end
          end else begin
            miss_d = '0;
            if ((state_q == TRACK) && (radius >= R_NEAR_V))     state_d = HOLD;
            else if ((state_q == HOLD) && (radius < R_LEAVE_V)) state_d = TRACK;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Target duty follows the current state and the last detected centroid error.
  always_comb begin
    mag        = err_q[11] ? $unsigned(-err_q) : $unsigned(err_q);
    corr       = corr_sat(mag >> TURN_SHIFT);
    outer      = duty_sat(BASE_V, corr);
    inner      = BASE_V - corr;
    tgt_duty_l = 8'd0;
    tgt_duty_r = 8'd0;
    tgt_dir_l  = 1'b1;
    tgt_dir_r  = 1'b1;
    case (state_q)
      SEARCH: begin
        tgt_duty_l = SEARCH_V;
        tgt_duty_r = SEARCH_V;
        tgt_dir_r  = 1'b0;
      end
      TRACK: begin
        if (mag <= TOL_V) begin
          tgt_duty_l = BASE_V;
          tgt_duty_r = BASE_V;
        end else if (err_q[11]) begin
          tgt_duty_l = inner;
          tgt_duty_r = outer;
        end else begin
          tgt_duty_l = outer;
          tgt_duty_r = inner;
        end
      end
      default: ;
    endcase
  end

  // PWM timebase; active settings swap only at period boundaries, except stop-on-IDLE.
  always_comb begin
    pre_wrap     = (pre_q == PRE_LAST);
    pre_d        = pre_wrap ? '0 : pre_q + PRE_W'(1);
    cnt_d        = pre_wrap ? cnt_q + 8'd1 : cnt_q;
    period_start = pre_wrap && (cnt_q == 8'hFF);
    act_duty_l_d = act_duty_l_q;
    act_duty_r_d = act_duty_r_q;
    act_dir_l_d  = act_dir_l_q;
    act_dir_r_d  = act_dir_r_q;
    if (period_start) begin
      act_duty_l_d = tgt_duty_l;
      act_duty_r_d = tgt_duty_r;
      act_dir_l_d  = tgt_dir_l;
      act_dir_r_d  = tgt_dir_r;
    end
    if (state_d == IDLE) begin
      act_duty_l_d = 8'd0;
      act_duty_r_d = 8'd0;
      act_dir_l_d  = 1'b1;
      act_dir_r_d  = 1'b1;
    end
    pwm_l_d = (state_d != IDLE) && (cnt_q < act_duty_l_q);
    pwm_r_d = (state_d != IDLE) && (cnt_q < act_duty_r_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      miss_q       <= '0;
      err_q        <= '0;
      pre_q        <= '0;
      cnt_q        <= '0;
      act_duty_l_q <= '0;
      act_duty_r_q <= '0;
      act_dir_l_q  <= 1'b1;
      act_dir_r_q  <= 1'b1;
      pwm_l_q      <= 1'b0;
      pwm_r_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      miss_q       <= miss_d;
      err_q        <= err_d;
      pre_q        <= pre_d;
      cnt_q        <= cnt_d;
      act_duty_l_q <= act_duty_l_d;
      act_duty_r_q <= act_duty_r_d;
      act_dir_l_q  <= act_dir_l_d;
      act_dir_r_q  <= act_dir_r_d;
      pwm_l_q      <= pwm_l_d;
      pwm_r_q      <= pwm_r_d;
    end
  end

  assign pwm_l = pwm_l_q;
  assign pwm_r = pwm_r_q;
  assign dir_l = act_dir_l_q;
  assign dir_r = act_dir_r_q;
  assign state = state_q;

endmodule

// File: tb/tb_chase_steer.sv
// Scoreboard bench for chase_steer (PWM_DIV=1): stimulus queues expectations,
// a negedge monitor pops them and measures state, directions and PWM duty.
module tb_chase_steer;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        enable = 1'b0;
  logic        meas_valid = 1'b0;
  logic [10:0] x_center = '0;
  logic [11:0] radius = '0;
  logic        pwm_l, pwm_r, dir_l, dir_r;
  logic [1:0]  state;

  chase_steer #(.PWM_DIV(1)) dut (
    .clk(clk), .reset(reset), .enable(enable), .meas_valid(meas_valid),
    .x_center(x_center), .radius(radius), .pwm_l(pwm_l), .pwm_r(pwm_r),
    .dir_l(dir_l), .dir_r(dir_r), .state(state)
  );

  always #5 clk = ~clk;

  // kind 0: state only; 1: state, dirs, high-count over one 256-step period; 2: state, dirs, instant pwm
  typedef struct {
    int    kind;
    string name;
    int    st;
    int    dl;
    int    dr;
    int    pl;
    int    pr;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  bit   busy = 1'b0;

  task automatic check(input string nm, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic expect_(input int kind, input string nm, input int st,
                         input int dl, input int dr, input int pl, input int pr);
    exp_t e;
    e.kind = kind; e.name = nm; e.st = st;
    e.dl = dl; e.dr = dr; e.pl = pl; e.pr = pr;
    q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    int hl, hr;
    forever begin
      @(negedge clk);
      if (q.size() != 0) begin
        busy = 1'b1;
        e = q.pop_front();
        check({e.name, ".state"}, int'(state), e.st);
        if (e.kind != 0) begin
          check({e.name, ".dir_l"}, int'(dir_l), e.dl);
          check({e.name, ".dir_r"}, int'(dir_r), e.dr);
        end
        if (e.kind == 2) begin
          check({e.name, ".pwm_l"}, int'(pwm_l), e.pl);
          check({e.name, ".pwm_r"}, int'(pwm_r), e.pr);
        end
        if (e.kind == 1) begin
          hl = 0;
          hr = 0;
          for (int i = 0; i < 256; i++) begin
            hl += int'(pwm_l);
            hr += int'(pwm_r);
            @(negedge clk);
          end
          check({e.name, ".duty_l"}, hl, e.pl);
          check({e.name, ".duty_r"}, hr, e.pr);
        end
        busy = 1'b0;
      end
    end
  end

  task automatic wait_idle();
    int n;
    n = 0;
    while ((q.size() != 0 || busy) && n < 2000) begin
      @(posedge clk);
      n++;
    end
    if (n >= 2000) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_drain: %0d entries pending after 2000 cycles, expected 0", q.size());
    end
  endtask

  task automatic settle();
    repeat (300) @(posedge clk);
    #1;
  endtask

  task automatic meas(input int x, input int r, input int st, input string nm);
    @(posedge clk); #1;
    meas_valid = 1'b1;
    x_center   = 11'(x);
    radius     = 12'(r);
    @(posedge clk); #1;
    meas_valid = 1'b0;
    expect_(0, nm, st, 0, 0, 0, 0);
    wait_idle();
  endtask

  task automatic track_duty(input int x, input string nm, input int l, input int r);
    meas(x, 20, 2, nm);
    settle();
    expect_(1, nm, 2, 1, 1, l, r);
    wait_idle();
  endtask

  task automatic wait_rise(input bit use_l);
    logic prev, cur;
    int   n;
    prev = use_l ? pwm_l : pwm_r;
    n = 0;
    forever begin
      @(posedge clk); #1;
      cur = use_l ? pwm_l : pwm_r;
      if (!prev && cur) break;
      prev = cur;
      n++;
      if (n > 600) begin
        checks++;
        errors++;
        $display("FAIL pwm_rise: no rising edge within 600 cycles, expected one");
        break;
      end
    end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    @(posedge clk); #1;
    expect_(2, "reset_values", 0, 1, 1, 0, 0);
    wait_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    expect_(1, "idle_period", 0, 1, 1, 0, 0);
    wait_idle();

    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    expect_(0, "enable_to_search", 1, 0, 0, 0, 0);
    wait_idle();
    settle();
    expect_(1, "search_spin", 1, 1, 0, 96, 96);
    wait_idle();

    track_duty(512,  "acquire_center", 160, 160);
    track_duty(832,  "target_right", 200, 120);
    track_duty(192,  "target_left", 120, 200);
    track_duty(576,  "tol_edge_in", 160, 160);
    track_duty(577,  "tol_edge_out", 168, 152);
    track_duty(1023, "far_right", 223, 97);
    track_duty(0,    "far_left", 96, 224);

    meas(512, 60, 3, "near_to_hold");
    settle();
    expect_(1, "hold_stopped", 3, 1, 1, 0, 0);
    wait_idle();
    meas(512, 55, 3, "hold_r55");
    meas(512, 52, 3, "hold_r52");
    meas(512, 51, 2, "hold_leave_r51");
    settle();
    expect_(1, "retrack_duty", 2, 1, 1, 160, 160);
    wait_idle();

    for (int i = 0; i < 7; i++) meas(512, 0, 2, "miss_under_limit");
    meas(512, 0, 1, "miss_lost");
    meas(512, 20, 2, "reacquire");
    for (int i = 0; i < 5; i++) meas(512, 0, 2, "miss_partial");
    meas(512, 20, 2, "miss_clear");
    for (int i = 0; i < 7; i++) meas(512, 0, 2, "miss_after_clear");
    meas(512, 0, 1, "miss_lost_again");

    @(posedge clk); #1;
    meas_valid = 1'b1; x_center = 11'd512; radius = 12'd20;
    @(posedge clk); #1;
    radius = 12'd60;
    expect_(0, "b2b_first", 2, 0, 0, 0, 0);
    @(posedge clk); #1;
    meas_valid = 1'b0;
    expect_(0, "b2b_second", 3, 0, 0, 0, 0);
    wait_idle();

    meas(512, 51, 2, "b2b_leave_hold");
    meas(832, 20, 2, "pre_stop_track");
    settle();

    wait_rise(1'b0);
    enable = 1'b0; meas_valid = 1'b1; x_center = 11'd512; radius = 12'd60;
    @(posedge clk); #1;
    meas_valid = 1'b0;
    expect_(2, "enable_off_stop", 0, 1, 1, 0, 0);
    wait_idle();
    meas(512, 20, 0, "idle_ignores_meas");
    settle();
    expect_(1, "idle_after_off", 0, 1, 1, 0, 0);
    wait_idle();

    @(posedge clk); #1;
    enable = 1'b1;
    @(posedge clk); #1;
    expect_(0, "reenable_search", 1, 0, 0, 0, 0);
    wait_idle();
    settle();
    wait_rise(1'b1);
    #2;
    reset = 1'b0;
    expect_(2, "async_reset", 0, 1, 1, 0, 0);
    wait_idle();
    @(posedge clk); #1;
    reset = 1'b1;
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
